seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit 7-segment display built around one shared `bcd_to_7seg` decoder. It holds a frame of packed BCD digits and cycles through them, presenting one digit at a time to the decoder. It drives the returned segment pattern and a one-hot digit enable with dead-time between digits. Frame updates are double-buffered so a new value never tears mid-scan.

---
 rtl/seg_scan_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered BCD frame, one shared
// external decoder, one-hot digit enables with a dead-time window at the start of each slot.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank_lz,
    output logic [3:0]              bcd,
    input  logic [6:0]              seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_start,
    output logic                    state_dbg
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] disp;

    logic                    slot_end;
    logic                    wrap;
    logic [CW-1:0]           next_cnt;
    logic [IW-1:0]           next_idx;
    logic [4*NUM_DIGITS-1:0] disp_next;
    logic [3:0]              next_digit;
    logic [3:0]              cur_digit;
    logic                    upper_zero;
    logic                    suppress;
    logic                    enter_drive;

    always_comb begin
        slot_end    = (cnt == LAST_CNT);
        wrap        = slot_end && (idx == LAST_IDX);
        next_cnt    = slot_end ? '0 : cnt + 1'b1;
        next_idx    = wrap ? '0 : (slot_end ? idx + 1'b1 : idx);
        // The shadow only moves into the display at the frame wrap, so a frame never tears.
        disp_next   = (wrap && pending) ? shadow : disp;
        next_digit  = disp_next[4*int'(next_idx) +: 4];
        cur_digit   = disp[4*int'(idx) +: 4];
        upper_zero  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && disp[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        suppress    = (cur_digit > 4'd9) || (blank_lz && (idx != '0) && upper_zero);
        enter_drive = (int'(next_cnt) >= DEAD);
    end

    // load is a one-cycle strobe with no backpressure: every asserted cycle is accepted
    // and the most recent value in the shadow register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BLANK;
            idx     <= '0;
            cnt     <= '0;
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
            bcd     <= 4'd0;
            seg_out <= 7'd0;
            an      <= '0;
        end else begin
            cnt  <= next_cnt;
            idx  <= next_idx;
            disp <= disp_next;
            if (load) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
            if (slot_end) bcd <= next_digit;
            // bcd is stable for the whole slot, so seg is settled by the first DRIVE edge.
            if (enter_drive) begin
                state   <= DRIVE;
                an      <= NUM_DIGITS'(1) << next_idx;
                seg_out <= suppress ? 7'd0 : seg;
            end else begin
                state   <= BLANK;
                an      <= '0;
                seg_out <= 7'd0;
            end
        end
    end

    assign frame_start = !rst && (idx == '0) && (cnt == '0);
    assign state_dbg   = (state == DRIVE);

endmodule
